bcd_down_counter_999: RTL and testbench

- Loadable 3-digit BCD down-counter/countdown timer, 999..000.
- Counts in the opposite direction to the team's 000-999 BCD up-counter and uses the same digit interface: d2 = hundreds, d1 = tens, d0 = units, each 4-bit BCD.
- Drives the shared 7-segment/digit path.
- Signals terminal count to the control logic.

---
 rtl/bcd_down_counter_999.sv | 182 ++++++++++++++++++
 tb/tb_bcd_down_counter_999.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter_999.sv
// Loadable 3-digit BCD countdown timer, 999..000, with terminal-count pulse.
// Optional periodic auto-reload is enabled with `define BCD_AUTO_RELOAD_EN.
module bcd_down_counter_999 #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_d2,
    input  logic [3:0] load_d1,
    input  logic [3:0] load_d0,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [3:0]    d2_q, d2_d;
    logic [3:0]    d1_q, d1_d;
    logic [3:0]    d0_q, d0_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    ld2, ld1, ld0;
    logic [3:0]    dec2, dec1, dec0;
    logic          dec_zero;
    logic          val_zero;

    // Out-of-range preset digits saturate at 9 so the invariant holds.
    function automatic logic [3:0] clamp9(input logic [3:0] x);
        return (x > 4'd9) ? 4'd9 : x;
    endfunction

    assign ld2 = clamp9(load_d2);
    assign ld1 = clamp9(load_d1);
    assign ld0 = clamp9(load_d0);

`ifdef BCD_AUTO_RELOAD_EN
    logic [3:0] rl2_q, rl1_q, rl0_q;
    logic [3:0] rl2_d, rl1_d, rl0_d;
    logic       rl_zero;

    assign rl_zero = ({rl2_q, rl1_q, rl0_q} == 12'h000);

    // Reload register follows each accepted (clamped) preset.
    always_comb begin
        rl2_d = rl2_q;
        rl1_d = rl1_q;
        rl0_d = rl0_q;
        if (load) begin
            rl2_d = ld2;
            rl1_d = ld1;
            rl0_d = ld0;
        end
    end

    // Reload register storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rl2_q <= 4'd0;
            rl1_q <= 4'd0;
            rl0_q <= 4'd0;
        end else begin
            rl2_q <= rl2_d;
            rl1_q <= rl1_d;
            rl0_q <= rl0_d;
        end
    end
`endif

    // BCD borrow chain; never evaluated at 000 while running.
    always_comb begin
        dec2 = d2_q;
        dec1 = d1_q;
        dec0 = d0_q - 4'd1;
        if (d0_q == 4'd0) begin
            dec0 = 4'd9;
            if (d1_q == 4'd0) begin
                dec1 = 4'd9;
                dec2 = d2_q - 4'd1;
            end else begin
                dec1 = d1_q - 4'd1;
            end
        end
    end

    assign dec_zero = ({dec2, dec1, dec0} == 12'h000);
    assign val_zero = ({d2_q, d1_q, d0_q} == 12'h000);

    // Next-state: load > start > pause, then prescaled countdown.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        done_d  = 1'b0;
        if (load) begin
            d2_d    = ld2;
            d1_d    = ld1;
            d0_d    = ld0;
            state_d = S_IDLE;
            ps_d    = '0;
        end else if (start && (state_q == S_IDLE || state_q == S_PAUSED)) begin
            if (val_zero) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else if (pause && state_q == S_RUN) begin
            state_d = S_PAUSED;
        end else if (state_q == S_RUN) begin
            if (ps_q == PS_MAX) begin
                ps_d = '0;
                d2_d = dec2;
                d1_d = dec1;
                d0_d = dec0;
                if (dec_zero) begin
                    done_d  = 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
                    if (!rl_zero) begin
                        d2_d = rl2_q;
                        d1_d = rl1_q;
                        d0_d = rl0_q;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end else begin
                ps_d = ps_q + PW'(1);
            end
        end
        busy_d = (state_d == S_RUN);
    end

    // State, prescaler, digits and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ps_q    <= '0;
            d2_q    <= 4'd0;
            d1_q    <= 4'd0;
            d0_q    <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d2   = d2_q;
    assign d1   = d1_q;
    assign d0   = d0_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_down_counter_999.sv
// Directed bench for bcd_down_counter_999 (TICK_DIV=1 and TICK_DIV=3 instances).
// Auto-reload vectors run only when BCD_AUTO_RELOAD_EN is defined.
module tb_bcd_down_counter_999;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] load_d2 = 4'd0;
    logic [3:0] load_d1 = 4'd0;
    logic [3:0] load_d0 = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [3:0] a2, a1, a0;
    logic       a_busy, a_done;
    logic [3:0] b2, b1, b0;
    logic       b_busy, b_done;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bcd_down_counter_999 #(.TICK_DIV(1)) u_dut1 (
        .clock(clock), .reset(reset), .load(load),
        .load_d2(load_d2), .load_d1(load_d1), .load_d0(load_d0),
        .start(start), .pause(pause),
        .d2(a2), .d1(a1), .d0(a0), .busy(a_busy), .done(a_done)
    );

    bcd_down_counter_999 #(.TICK_DIV(3)) u_dut3 (
        .clock(clock), .reset(reset), .load(load),
        .load_d2(load_d2), .load_d1(load_d1), .load_d0(load_d0),
        .start(start), .pause(pause),
        .d2(b2), .d1(b1), .d0(b0), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int va();
        return int'({a2, a1, a0});
    endfunction

    function automatic int vb();
        return int'({b2, b1, b0});
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] u);
        load_d2 = h;
        load_d1 = t;
        load_d0 = u;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_val", va(), 'h000);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);

        // borrow chain 100 -> 000
        do_load(4'd1, 4'd0, 4'd0);
        chk("ld100", va(), 'h100);
        chk("ld100_busy", int'(a_busy), 0);
        do_start();
        chk("st100_val", va(), 'h100);
        chk("st100_busy", int'(a_busy), 1);
        for (int i = 99; i >= 1; i--) begin
            tick();
            chk("chain_val", va(), bcd(i));
            chk("chain_done", int'(a_done), 0);
        end
        chk("chain_busy", int'(a_busy), 1);
        tick();
        chk("tc_val", va(), 'h000);
        chk("tc_done", int'(a_done), 1);
        chk("tc_busy", int'(a_busy), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_val", va(), 'h000);
            chk("hold_done", int'(a_done), 0);
        end

        // clamping and prescaler (TICK_DIV=3)
        do_load(4'hC, 4'h2, 4'hF);
        chk("clamp", vb(), 'h929);
        do_start();
        chk("ps_k", vb(), 'h929);
        chk("ps_busy", int'(b_busy), 1);
        tick();
        chk("ps_k1", vb(), 'h929);
        tick();
        chk("ps_k2", vb(), 'h929);
        tick();
        chk("ps_k3", vb(), 'h928);
        tick();
        chk("ps_k4", vb(), 'h928);
        tick();
        chk("ps_k5", vb(), 'h928);
        tick();
        chk("ps_k6", vb(), 'h927);

        // pause / resume / priority
        do_load(4'd0, 4'd1, 4'd2);
        do_start();
        chk("pr_start", va(), 'h012);
        tick();
        chk("pr_011", va(), 'h011);
        tick();
        chk("pr_010", va(), 'h010);
        pause = 1'b1;
        tick();
        pause = 1'b0;
        chk("pause_val", va(), 'h010);
        chk("pause_busy", int'(a_busy), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("paused_val", va(), 'h010);
            chk("paused_busy", int'(a_busy), 0);
        end
        start = 1'b1;
        pause = 1'b1;
        tick();
        start = 1'b0;
        pause = 1'b0;
        chk("resume_val", va(), 'h010);
        chk("resume_busy", int'(a_busy), 1);
        tick();
        chk("resume_009", va(), 'h009);
        load_d2 = 4'd0;
        load_d1 = 4'd5;
        load_d0 = 4'd0;
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        chk("ldst_val", va(), 'h050);
        chk("ldst_busy", int'(a_busy), 0);
        tick();
        chk("ldst_hold", va(), 'h050);
        chk("ldst_busy2", int'(a_busy), 0);

        // start at zero
        do_load(4'd0, 4'd0, 4'd0);
        do_start();
        chk("z_val", va(), 'h000);
        chk("z_done", int'(a_done), 1);
        chk("z_busy", int'(a_busy), 0);
        tick();
        chk("z_done2", int'(a_done), 0);
        chk("z_busy2", int'(a_busy), 0);
        do_start();
        chk("z_restart_done", int'(a_done), 0);

        // asynchronous reset mid-count
        do_load(4'd0, 4'd0, 4'd5);
        do_start();
        tick();
        chk("rm_004", va(), 'h004);
        tick();
        chk("rm_003", va(), 'h003);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_val", va(), 'h000);
        chk("rm_busy", int'(a_busy), 0);
        chk("rm_done", int'(a_done), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rm_after", va(), 'h000);

`ifdef BCD_AUTO_RELOAD_EN
        // periodic reload
        do_load(4'd0, 4'd0, 4'd2);
        do_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_001", va(), 'h001);
            chk("ar_nodone", int'(a_done), 0);
            tick();
            chk("ar_002", va(), 'h002);
            chk("ar_done", int'(a_done), 1);
            chk("ar_busy", int'(a_busy), 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
